// File: rtl/ch3_wave_engine.sv
// Channel 3 (wave) playback engine: period counter, wave-RAM nibble fetch,
// 256-step length timer, volume shifter and NR52 channel-active flag.
module ch3_wave_engine #(
    parameter int FREQ_W = 11,
    parameter int POS_W  = 5,
    parameter int LEN_W  = 9
) (
    input  logic              cery_2mhz,
    input  logic              napu_reset,
    input  logic              dac_en,
    input  logic              len_wr,
    input  logic [7:0]        len_data,
    input  logic              len_tick,
    input  logic [1:0]        vol_code,
    input  logic [FREQ_W-1:0] freq,
    input  logic              len_en,
    input  logic              trigger,
    output logic              wave_rd,
    output logic [POS_W-2:0]  wave_addr,
    input  logic [7:0]        wave_data,
    output logic [FREQ_W-1:0] freq_cnt,
    output logic              ch3_active,
    output logic [3:0]        sample
);

    localparam logic [FREQ_W-1:0] FREQ_MAX = '1;
    localparam logic [LEN_W-1:0]  LEN_FULL = LEN_W'(256);

    logic [FREQ_W-1:0] r_freq_cnt;
    logic [POS_W-1:0]  r_pos;
    logic [LEN_W-1:0]  r_len;
    logic [3:0]        r_buf;
    logic              r_active;
    logic              r_wave_rd;
    logic [POS_W-2:0]  r_wave_addr;
    logic              r_fetch_lo;
    logic [3:0]        r_sample;

    logic              w_wrap;
    logic [POS_W-1:0]  w_pos_inc;
    logic [FREQ_W-1:0] w_freq_cnt_next;
    logic [POS_W-1:0]  w_pos_next;
    logic [LEN_W-1:0]  w_len_dec;
    logic [LEN_W-1:0]  w_len_next;
    logic              w_expire;
    logic              w_active_next;
    logic [3:0]        w_nibble;
    logic [3:0]        w_buf_next;
    logic [3:0]        w_scaled;

    assign w_len_dec = r_len - 1'b1;
    assign w_pos_inc = r_pos + 1'b1;

    always_comb begin
        w_wrap          = r_active && (r_freq_cnt == FREQ_MAX) && !trigger;
        w_freq_cnt_next = r_freq_cnt;
        w_pos_next      = r_pos;
        if (trigger) begin
            w_freq_cnt_next = freq;
            w_pos_next      = '0;
        end else if (r_active) begin
            w_freq_cnt_next = (r_freq_cnt == FREQ_MAX) ? freq : r_freq_cnt + 1'b1;
            if (w_wrap) begin
                w_pos_next = w_pos_inc;
            end
        end
    end

    // Length priority: register write, then trigger reload, then tick decrement.
    always_comb begin
        w_len_next = r_len;
        w_expire   = 1'b0;
        if (len_wr) begin
            w_len_next = LEN_FULL - LEN_W'(len_data);
        end else if (trigger) begin
            if (r_len == '0) begin
                w_len_next = LEN_FULL;
            end
        end else if (len_tick && len_en && (r_len != '0)) begin
            w_len_next = w_len_dec;
            w_expire   = (w_len_dec == '0);
        end
    end

    always_comb begin
        w_active_next = r_active;
        if (!dac_en) begin
            w_active_next = 1'b0;
        end else if (trigger) begin
            w_active_next = 1'b1;
        end else if (w_expire) begin
            w_active_next = 1'b0;
        end
    end

    // wave_data is presented while wave_rd is high; a trigger drops that fetch.
    always_comb begin
        w_nibble   = r_fetch_lo ? wave_data[3:0] : wave_data[7:4];
        w_buf_next = (r_wave_rd && !trigger) ? w_nibble : r_buf;
        case (vol_code)
            2'd0:    w_scaled = 4'd0;
            2'd1:    w_scaled = w_buf_next;
            2'd2:    w_scaled = w_buf_next >> 1;
            default: w_scaled = w_buf_next >> 2;
        endcase
    end

    always_ff @(posedge cery_2mhz) begin
        if (!napu_reset) begin
            r_freq_cnt  <= '0;
            r_pos       <= '0;
            r_len       <= '0;
            r_buf       <= '0;
            r_active    <= 1'b0;
            r_wave_rd   <= 1'b0;
            r_wave_addr <= '0;
            r_fetch_lo  <= 1'b0;
            r_sample    <= '0;
        end else begin
            r_freq_cnt <= w_freq_cnt_next;
            r_pos      <= w_pos_next;
            r_len      <= w_len_next;
            r_buf      <= w_buf_next;
            r_active   <= w_active_next;
            r_wave_rd  <= w_wrap;
            if (w_wrap) begin
                r_wave_addr <= w_pos_inc[POS_W-1:1];
                r_fetch_lo  <= w_pos_inc[0];
            end
            r_sample <= w_active_next ? w_scaled : 4'd0;
        end
    end

    assign wave_rd    = r_wave_rd;
    assign wave_addr  = r_wave_addr;
    assign freq_cnt   = r_freq_cnt;
    assign ch3_active = r_active;
    assign sample     = r_sample;

endmodule

// File: tb/tb_ch3_wave_engine.sv
// Self-checking bench for ch3_wave_engine: directed vector table, corner-case
// sequences and a randomized run against a behavioural channel-3 model.
module tb_ch3_wave_engine;

    logic        clk = 1'b0;
    logic        napu_reset, dac_en, len_wr, len_tick, len_en, trigger;
    logic [7:0]  len_data, wave_data;
    logic [1:0]  vol_code;
    logic [10:0] freq, freq_cnt;
    logic        wave_rd, ch3_active;
    logic [3:0]  wave_addr, sample;
    logic [7:0]  ram [16];

    always #5 clk = ~clk;

    ch3_wave_engine dut (
        .cery_2mhz (clk),
        .napu_reset(napu_reset),
        .dac_en    (dac_en),
        .len_wr    (len_wr),
        .len_data  (len_data),
        .len_tick  (len_tick),
        .vol_code  (vol_code),
        .freq      (freq),
        .len_en    (len_en),
        .trigger   (trigger),
        .wave_rd   (wave_rd),
        .wave_addr (wave_addr),
        .wave_data (wave_data),
        .freq_cnt  (freq_cnt),
        .ch3_active(ch3_active),
        .sample    (sample)
    );

    // Wave RAM answers during the wave_rd cycle; junk otherwise.
    always @(negedge clk) wave_data = wave_rd ? ram[wave_addr] : 8'($urandom);

    typedef struct {
        bit        rst_n;
        bit        dac;
        bit        lwr;
        bit [7:0]  ldata;
        bit        tick;
        bit [1:0]  vol;
        bit [10:0] freq;
        bit        len_en;
        bit        trig;
    } in_t;

    typedef struct {
        in_t in;
        int  e_act, e_smp, e_rd, e_addr, e_cnt;
    } vec_t;

    int  n_checks = 0;
    int  n_pass   = 0;
    in_t cur;
    vec_t vt [14];

    // Behavioural model: channel state as plain integers, fetches as a queue.
    int m_cnt = 0, m_pos = 0, m_len = 0, m_buf = 0, m_addr = 0, m_sample = 0;
    int m_active = 0, m_rd = 0;
    int fetch_q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step(input in_t v);
        int new_len;
        int expire;
        int b;
        if (!v.rst_n) begin
            m_cnt = 0; m_pos = 0; m_len = 0; m_buf = 0; m_addr = 0;
            m_sample = 0; m_active = 0; m_rd = 0;
            fetch_q.delete();
            return;
        end
        if (v.trig) fetch_q.delete();
        if (fetch_q.size() > 0) m_buf = fetch_q.pop_front();
        new_len = m_len;
        expire  = 0;
        if (v.lwr) new_len = 256 - int'(v.ldata);
        else if (v.trig) begin
            if (m_len == 0) new_len = 256;
        end else if (v.tick && v.len_en && m_len > 0) begin
            new_len = m_len - 1;
            expire  = (new_len == 0);
        end
        m_len = new_len;
        m_rd  = 0;
        if (v.trig) begin
            m_cnt = int'(v.freq);
            m_pos = 0;
        end else if (m_active != 0) begin
            if (m_cnt == 2047) begin
                m_cnt  = int'(v.freq);
                m_pos  = (m_pos + 1) % 32;
                m_addr = m_pos / 2;
                m_rd   = 1;
                b      = int'(ram[m_addr]);
                fetch_q.push_back((m_pos % 2 == 0) ? b / 16 : b % 16);
            end else m_cnt = m_cnt + 1;
        end
        if (!v.dac) m_active = 0;
        else if (v.trig) m_active = 1;
        else if (expire != 0) m_active = 0;
        m_sample = (m_active == 0 || v.vol == 0) ? 0 : (m_buf >> (int'(v.vol) - 1));
    endtask

    task automatic cyc(input in_t v);
        napu_reset = v.rst_n;  dac_en  = v.dac;   len_wr   = v.lwr;
        len_data   = v.ldata;  len_tick = v.tick; vol_code = v.vol;
        freq       = v.freq;   len_en  = v.len_en; trigger = v.trig;
        @(posedge clk);
        model_step(v);
        #1;
        chk("model_active",   int'(ch3_active), m_active);
        chk("model_sample",   int'(sample),     m_sample);
        chk("model_wave_rd",  int'(wave_rd),    m_rd);
        chk("model_wave_addr", int'(wave_addr), m_addr);
        chk("model_freq_cnt", int'(freq_cnt),   m_cnt);
    endtask

    task automatic step();
        cyc(cur);
        cur.trig = 0; cur.lwr = 0; cur.tick = 0;
    endtask

    function automatic vec_t mk(input bit rst_n, input bit trig, input int ea,
                                input int es, input int er, input int eaddr, input int ecnt);
        vec_t r;
        r.in.rst_n = rst_n; r.in.dac = 1; r.in.lwr = 0; r.in.ldata = 0; r.in.tick = 0;
        r.in.vol = 1; r.in.freq = 11'd2046; r.in.len_en = 0; r.in.trig = trig;
        r.e_act = ea; r.e_smp = es; r.e_rd = er; r.e_addr = eaddr; r.e_cnt = ecnt;
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++)
            ram[i] = 8'((((2 * (i % 8) + 1) % 16) << 4) | ((2 * (i % 8) + 2) % 16));

        // Period-2 playback: wave_rd every other cycle, sample one cycle after.
        vt[0]  = mk(0, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(0, 0, 0, 0, 0, 0, 0);
        vt[2]  = mk(1, 1, 1, 0, 0, 0, 2046);
        vt[3]  = mk(1, 0, 1, 0, 0, 0, 2047);
        vt[4]  = mk(1, 0, 1, 0, 1, 0, 2046);
        vt[5]  = mk(1, 0, 1, 2, 0, 0, 2047);
        vt[6]  = mk(1, 0, 1, 2, 1, 1, 2046);
        vt[7]  = mk(1, 0, 1, 3, 0, 1, 2047);
        vt[8]  = mk(1, 0, 1, 3, 1, 1, 2046);
        vt[9]  = mk(1, 0, 1, 4, 0, 1, 2047);
        vt[10] = mk(1, 0, 1, 4, 1, 2, 2046);
        vt[11] = mk(1, 0, 1, 5, 0, 2, 2047);
        vt[12] = mk(1, 0, 1, 5, 1, 2, 2046);
        vt[13] = mk(1, 0, 1, 6, 0, 2, 2047);
        for (int i = 0; i < 14; i++) begin
            cyc(vt[i].in);
            chk("vec_active",   int'(ch3_active), vt[i].e_act);
            chk("vec_sample",   int'(sample),     vt[i].e_smp);
            chk("vec_wave_rd",  int'(wave_rd),    vt[i].e_rd);
            chk("vec_wave_addr", int'(wave_addr), vt[i].e_addr);
            chk("vec_freq_cnt", int'(freq_cnt),   vt[i].e_cnt);
            $display("vec %0d: active=%0d sample=%0d rd=%0d addr=%0d cnt=%0d",
                     i, ch3_active, sample, wave_rd, wave_addr, freq_cnt);
        end
        cur = vt[13].in;

        // Position wrap 31->0 at full rate, leaving buffer = 0xA.
        ram[0] = 8'hA7;
        cur.freq = 11'd2047; cur.trig = 1; step();
        for (int k = 1; k <= 33; k++) begin
            step();
            if (k == 31) begin chk("wrap_addr31", int'(wave_addr), 15); chk("wrap_rd31", int'(wave_rd), 1); end
            if (k == 32) begin chk("wrap_addr0", int'(wave_addr), 0); chk("wrap_rd0", int'(wave_rd), 1); end
            if (k == 33) chk("wrap_sample", int'(sample), 10);
        end
        $display("wrap sequence done: sample=%0d", sample);

        // Retrigger discards the in-flight fetch; old buffer plays until first advance.
        cur.freq = 11'd2040; cur.trig = 1; step();
        chk("quirk_trig_sample", int'(sample), 10);
        chk("quirk_trig_rd", int'(wave_rd), 0);
        chk("quirk_trig_cnt", int'(freq_cnt), 2040);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("quirk_hold_sample", int'(sample), 10);
            chk("quirk_rd", int'(wave_rd), (k == 8) ? 1 : 0);
        end
        chk("quirk_first_addr", int'(wave_addr), 0);
        step();
        chk("quirk_low_nibble", int'(sample), 7);
        $display("trigger quirk done: sample=%0d", sample);

        // Trigger coincident with counter wrap.
        cur.freq = 11'd2046; cur.trig = 1; step();
        step();
        chk("tw_pre_cnt", int'(freq_cnt), 2047);
        cur.trig = 1; step();
        chk("tw_no_rd", int'(wave_rd), 0);
        chk("tw_cnt", int'(freq_cnt), 2046);
        step(); step();
        chk("tw_first_rd", int'(wave_rd), 1);
        chk("tw_first_addr", int'(wave_addr), 0);
        $display("trigger/wrap done");

        // Length expiry, len_en=1 then len_en=0.
        cur.len_en = 1; cur.lwr = 1; cur.ldata = 8'd254; step();
        cur.trig = 1; step();
        cur.tick = 1; step();
        chk("len_tick1_active", int'(ch3_active), 1);
        cur.tick = 1; step();
        chk("len_expire_active", int'(ch3_active), 0);
        chk("len_expire_sample", int'(sample), 0);
        cur.len_en = 0; cur.lwr = 1; cur.ldata = 8'd254; step();
        cur.trig = 1; step();
        cur.tick = 1; step();
        cur.tick = 1; step();
        chk("len_disabled_active", int'(ch3_active), 1);
        $display("length expiry done");

        // len_wr and len_tick together: the write wins.
        cur.len_en = 1; cur.lwr = 1; cur.ldata = 8'hFF; cur.tick = 1; step();
        chk("wr_tick_active", int'(ch3_active), 1);
        cur.tick = 1; step();
        chk("wr_tick_kill", int'(ch3_active), 0);

        // Trigger with len=0 reloads 256.
        cur.trig = 1; step();
        chk("len256_trig_active", int'(ch3_active), 1);
        for (int k = 0; k < 255; k++) begin cur.tick = 1; step(); end
        chk("len256_255_active", int'(ch3_active), 1);
        cur.tick = 1; step();
        chk("len256_256_active", int'(ch3_active), 0);
        $display("length 256 done");

        // Volume shifter with buffer = 0xF, then DAC control.
        ram[0] = 8'hAF; cur.len_en = 0; cur.vol = 1;
        cur.freq = 11'd2047; cur.trig = 1; step();
        cur.freq = 11'd0; step();
        chk("vol_reload_new_freq", int'(freq_cnt), 0);
        step();
        chk("vol1_sample", int'(sample), 15);
        cur.vol = 2; step(); chk("vol2_sample", int'(sample), 7);
        cur.vol = 3; step(); chk("vol3_sample", int'(sample), 3);
        cur.vol = 0; step(); chk("vol0_sample", int'(sample), 0);
        cur.vol = 1; step(); chk("vol1_again", int'(sample), 15);
        cur.dac = 0; step();
        chk("dac_off_active", int'(ch3_active), 0);
        chk("dac_off_sample", int'(sample), 0);
        cur.trig = 1; step();
        chk("dac_off_trig", int'(ch3_active), 0);
        cur.dac = 1; step();
        chk("dac_on_no_trig", int'(ch3_active), 0);
        $display("volume/dac done");

        // Reset mid-playback with len=100.
        cur.lwr = 1; cur.ldata = 8'd156; step();
        cur.freq = 11'd2046; cur.trig = 1; step();
        for (int k = 0; k < 5; k++) step();
        cur.rst_n = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_active", int'(ch3_active), 0);
            chk("rst_sample", int'(sample), 0);
            chk("rst_rd", int'(wave_rd), 0);
            chk("rst_cnt", int'(freq_cnt), 0);
            chk("rst_addr", int'(wave_addr), 0);
        end
        cur.rst_n = 1;
        for (int k = 0; k < 10; k++) begin cur.tick = (k % 2 == 0); step(); end
        chk("post_rst_active", int'(ch3_active), 0);
        chk("post_rst_sample", int'(sample), 0);
        chk("post_rst_cnt", int'(freq_cnt), 0);
        $display("reset sequence done");

        // Randomized stimulus against the model.
        for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            cur.rst_n = ($urandom % 200) != 0;
            cur.dac   = ($urandom % 50) != 0;
            cur.lwr   = ($urandom % 40) == 0;
            cur.ldata = 8'($urandom);
            cur.tick  = ($urandom % 8) == 0;
            if ($urandom % 10 == 0) cur.vol = 2'($urandom);
            if ($urandom % 20 == 0)
                cur.freq = ($urandom % 4 == 0) ? 11'($urandom) : 11'(2030 + $urandom_range(0, 17));
            if ($urandom % 50 == 0) cur.len_en = ~cur.len_en;
            cur.trig  = ($urandom % 40) == 0;
            cyc(cur);
        end
        $display("random phase done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
